// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the op code map, the legal-op limit and the FSM state encoding.
package alu_arb_pkg;

    localparam int unsigned CTRL_W = 4;

    typedef logic [CTRL_W-1:0] op_t;

    localparam op_t OP_AND  = 4'd0;
    localparam op_t OP_OR   = 4'd1;
    localparam op_t OP_ADD  = 4'd2;
    localparam op_t OP_SLTI = 4'd3;
    localparam op_t OP_SLT  = 4'd4;
    localparam op_t OP_MUL  = 4'd5;
    localparam op_t OP_SUB  = 4'd6;
    localparam op_t OP_BEQ  = 4'd7;
    localparam op_t OP_SRA  = 4'd8;
    localparam op_t OP_SRAV = 4'd9;
    localparam op_t OP_BNE  = 4'd10;
    localparam op_t OP_LUI  = 4'd11;
    localparam op_t OP_MAX  = OP_LUI;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Codes above OP_MAX have no ALU meaning and are answered with an error.
    function automatic logic op_illegal(input op_t op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_owner ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: grant, capture
// operands, run the ALU for one cycle, then hold the response for the owner.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [2*DATA_W-1:0]   req_src1_i,
    input  logic [2*DATA_W-1:0]   req_src2_i,
    input  logic [2*CTRL_W-1:0]   req_ctrl_i,
    output logic [1:0]            resp_valid_o,
    input  logic [1:0]            resp_ready_i,
    output logic [DATA_W-1:0]     resp_result_o,
    output logic                  resp_zero_o,
    output logic                  resp_err_o,
    output logic [DATA_W-1:0]     alu_src1_o,
    output logic [DATA_W-1:0]     alu_src2_o,
    output logic [CTRL_W-1:0]     alu_ctrl_o,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic                  alu_zero_i
);

    state_t              state_q, state_nxt;
    logic                last_owner_q;
    logic                owner_q;
    logic [DATA_W-1:0]   src1_q, src2_q;
    op_t                 ctrl_q;
    logic [DATA_W-1:0]   result_q;
    logic                zero_q;
    logic                err_q;

    logic [1:0]          grant;
    logic                accept;
    logic                resp_load;
    logic                resp_done;

    rr_arb2 u_rr_arb2 (
        .valid      (req_valid_i),
        .last_owner (last_owner_q),
        .grant      (grant)
    );

    // Next state, handshake strobes and the state-decoded outputs.
    always_comb begin
        state_nxt    = state_q;
        req_ready_o  = 2'b00;
        resp_valid_o = 2'b00;
        accept       = 1'b0;
        resp_load    = 1'b0;
        resp_done    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = grant;
                if (grant != 2'b00) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                resp_load = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid_o = owner_q ? 2'b10 : 2'b01;
                if (resp_ready_i[owner_q]) begin
                    resp_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            ctrl_q       <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                owner_q <= grant[1];
                src1_q  <= grant[1] ? req_src1_i[2*DATA_W-1:DATA_W] : req_src1_i[DATA_W-1:0];
                src2_q  <= grant[1] ? req_src2_i[2*DATA_W-1:DATA_W] : req_src2_i[DATA_W-1:0];
                ctrl_q  <= grant[1] ? req_ctrl_i[2*CTRL_W-1:CTRL_W] : req_ctrl_i[CTRL_W-1:0];
            end
            // Illegal codes override whatever the ALU produced.
            if (resp_load) begin
                err_q    <= op_illegal(ctrl_q);
                result_q <= op_illegal(ctrl_q) ? '0 : alu_result_i;
                zero_q   <= op_illegal(ctrl_q) ? 1'b1 : alu_zero_i;
            end
            if (resp_done) begin
                last_owner_q <= owner_q;
            end
        end
    end

    assign alu_src1_o    = src1_q;
    assign alu_src2_o    = src2_q;
    assign alu_ctrl_o    = ctrl_q;
    assign resp_result_o = result_q;
    assign resp_zero_o   = zero_q;
    assign resp_err_o    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural shared ALU, scoreboard of expected
// responses pushed on accept and popped on response handshake.
module tb_alu_arbiter;

    localparam int unsigned DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst_i;
    logic [1:0]          req_valid_i;
    logic [1:0]          req_ready_o;
    logic [2*DATA_W-1:0] req_src1_i;
    logic [2*DATA_W-1:0] req_src2_i;
    logic [7:0]          req_ctrl_i;
    logic [1:0]          resp_valid_o;
    logic [1:0]          resp_ready_i;
    logic [DATA_W-1:0]   resp_result_o;
    logic                resp_zero_o;
    logic                resp_err_o;
    logic [DATA_W-1:0]   alu_src1_o;
    logic [DATA_W-1:0]   alu_src2_o;
    logic [3:0]          alu_ctrl_o;
    logic [DATA_W-1:0]   alu_result_i;
    logic                alu_zero_i;

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_src1_i    (req_src1_i),
        .req_src2_i    (req_src2_i),
        .req_ctrl_i    (req_ctrl_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_result_o (resp_result_o),
        .resp_zero_o   (resp_zero_o),
        .resp_err_o    (resp_err_o),
        .alu_src1_o    (alu_src1_o),
        .alu_src2_o    (alu_src2_o),
        .alu_ctrl_o    (alu_ctrl_o),
        .alu_result_i  (alu_result_i),
        .alu_zero_i    (alu_zero_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        vld;
        logic [DATA_W-1:0] res;
        logic              zero;
        logic              err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Environment ALU; illegal codes return junk the DUT must suppress.
    function automatic logic [DATA_W-1:0] alu_fn(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (op)
            4'd0:       return a & b;
            4'd1:       return a | b;
            4'd2:       return a + b;
            4'd3, 4'd4: return {31'd0, $signed(a) < $signed(b)};
            4'd5:       return 32'(a * b);
            4'd6, 4'd7, 4'd10: return a - b;
            4'd8:       return 32'($signed(b) >>> a[4:0]);
            4'd9:       return 32'($signed(a) >>> b[4:0]);
            4'd11:      return b << 16;
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb begin
        alu_result_i = alu_fn(alu_ctrl_o, alu_src1_o, alu_src2_o);
        alu_zero_i   = (alu_result_i == '0);
    end

    function automatic exp_t expect_of(input logic owner, input logic [3:0] op,
                                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        exp_t e;
        e.vld = owner ? 2'b10 : 2'b01;
        if (op > 4'd11) begin
            e.res = '0; e.zero = 1'b1; e.err = 1'b1;
        end else begin
            e.res = alu_fn(op, a, b); e.zero = (e.res == '0); e.err = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampling on the falling edge.
    int                acc_cyc = 0;
    logic [1:0]        prev_vld = 2'b00;
    logic              prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_res = '0;
    logic              prev_zero = 1'b0;
    logic              prev_err = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        logic own;
        if (rst_i) begin
            sb.delete();
            prev_vld  = 2'b00;
            prev_hold = 1'b0;
        end else begin
            if ((req_valid_i & req_ready_o) != 2'b00) begin
                own = req_ready_o[1];
                sb.push_back(expect_of(own,
                    own ? req_ctrl_i[7:4] : req_ctrl_i[3:0],
                    own ? req_src1_i[2*DATA_W-1:DATA_W] : req_src1_i[DATA_W-1:0],
                    own ? req_src2_i[2*DATA_W-1:DATA_W] : req_src2_i[DATA_W-1:0]));
                acc_cyc = cyc;
            end
            if (resp_valid_o != 2'b00 && prev_vld == 2'b00)
                check("latency", 64'(cyc), 64'(acc_cyc + 2));
            if (prev_hold) begin
                check("hold_vld", 64'(resp_valid_o), 64'(prev_vld));
                check("hold_res", 64'(resp_result_o), 64'(prev_res));
                check("hold_flags", 64'({resp_zero_o, resp_err_o}), 64'({prev_zero, prev_err}));
                check("hold_ready", 64'(req_ready_o), 64'd0);
            end
            if (resp_valid_o != 2'b00 && resp_ready_i[resp_valid_o[1]]) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_resp", 64'(resp_valid_o), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_owner", 64'(resp_valid_o), 64'(e.vld));
                    check("resp_result", 64'(resp_result_o), 64'(e.res));
                    check("resp_zero", 64'(resp_zero_o), 64'(e.zero));
                    check("resp_err", 64'(resp_err_o), 64'(e.err));
                end
            end
            prev_hold = (resp_valid_o != 2'b00) && !resp_ready_i[resp_valid_o[1]];
            prev_vld  = resp_valid_o;
            prev_res  = resp_result_o;
            prev_zero = resp_zero_o;
            prev_err  = resp_err_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic set_req(input int n, input logic [3:0] op,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (n == 0) begin
            req_ctrl_i[3:0] = op; req_src1_i[DATA_W-1:0] = a; req_src2_i[DATA_W-1:0] = b;
        end else begin
            req_ctrl_i[7:4] = op; req_src1_i[2*DATA_W-1:DATA_W] = a; req_src2_i[2*DATA_W-1:DATA_W] = b;
        end
    endtask

    // Wait for a handshake to complete and the DUT to be idle again.
    task automatic wait_done();
        int k;
        k = 0;
        while (!(resp_valid_o != 2'b00 && resp_ready_i[resp_valid_o[1]]) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) check("timeout_resp", 64'd1, 64'd0);
        tick();
    endtask

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 2'b00;
        resp_ready_i = 2'b00;
        req_src1_i   = '0;
        req_src2_i   = '0;
        req_ctrl_i   = '0;

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_rvalid", 64'(resp_valid_o), 64'd0);
        check("rst_result", 64'(resp_result_o), 64'd0);
        check("rst_flags", 64'({resp_zero_o, resp_err_o}), 64'd0);
        check("rst_alu", 64'({alu_src1_o, alu_ctrl_o}), 64'd0);
        check("rst_alu2", 64'(alu_src2_o), 64'd0);

        // Lone req0: 5 + 7
        tick();
        resp_ready_i = 2'b11;
        set_req(0, 4'd2, 32'd5, 32'd7);
        req_valid_i = 2'b01;
        @(negedge clk);
        check("t1_grant", 64'(req_ready_o), 64'b01);
        tick();
        req_valid_i = 2'b00;
        @(negedge clk);
        check("t1_exec_rvalid", 64'(resp_valid_o), 64'd0);
        @(negedge clk);
        check("t1_rvalid", 64'(resp_valid_o), 64'b01);
        check("t1_result", 64'(resp_result_o), 64'd12);
        check("t1_zero_err", 64'({resp_zero_o, resp_err_o}), 64'd0);
        tick();

        // Tie right after reset: req0 first, then req1
        do_reset();
        set_req(0, 4'd6, 32'd9, 32'd9);
        set_req(1, 4'd1, 32'h0000_00F0, 32'h0000_000F);
        req_valid_i = 2'b11;
        @(negedge clk);
        check("t2_grant0", 64'(req_ready_o), 64'b01);
        tick();
        req_valid_i = 2'b10;
        @(negedge clk);
        @(negedge clk);
        check("t2_r0", 64'({resp_valid_o, resp_result_o, resp_zero_o}), {30'd0, 2'b01, 32'd0, 1'b1});
        @(negedge clk);
        check("t2_grant1", 64'(req_ready_o), 64'b10);
        tick();
        req_valid_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("t2_r1", 64'({resp_valid_o, resp_result_o, resp_zero_o}), {30'd0, 2'b10, 32'hFF, 1'b0});
        tick();

        // Stall in RESP, non-owner ready ignored, req0 waits
        resp_ready_i = 2'b01;
        set_req(1, 4'd0, 32'hFFFF_0000, 32'h1234_5678);
        req_valid_i = 2'b10;
        @(negedge clk);
        check("t3_grant", 64'(req_ready_o), 64'b10);
        tick();
        set_req(0, 4'd11, 32'd0, 32'h0000_ABCD);
        req_valid_i = 2'b01;
        repeat (5) begin
            @(negedge clk);
            check("t3_ready_busy", 64'(req_ready_o), 64'd0);
        end
        check("t3_stall_res", 64'({resp_valid_o, resp_result_o}), {30'd0, 2'b10, 32'h1234_0000});
        tick();
        resp_ready_i = 2'b10;
        @(negedge clk);
        check("t3_hs_no_accept", 64'(req_ready_o), 64'd0);
        tick();
        @(negedge clk);
        check("t3_next_grant", 64'(req_ready_o), 64'b01);
        tick();
        req_valid_i  = 2'b00;
        resp_ready_i = 2'b11;
        wait_done();

        // Illegal op 13
        set_req(0, 4'd13, 32'd3, 32'd4);
        req_valid_i = 2'b01;
        @(negedge clk);
        tick();
        req_valid_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("t4_err", 64'({resp_valid_o, resp_result_o, resp_zero_o, resp_err_o}),
              {28'd0, 2'b01, 32'd0, 1'b1, 1'b1});
        tick();
        req_valid_i = 2'b01;
        @(negedge clk);
        check("t4_idle_again", 64'(req_ready_o), 64'b01);
        tick();
        req_valid_i = 2'b00;
        wait_done();

        // Reset while in RESP; then tie goes to req0
        resp_ready_i = 2'b00;
        set_req(1, 4'd2, 32'd1, 32'd1);
        req_valid_i = 2'b10;
        @(negedge clk);
        tick();
        req_valid_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("t5_in_resp", 64'(resp_valid_o), 64'b10);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        resp_ready_i = 2'b11;
        set_req(0, 4'd5, 32'd6, 32'd7);
        set_req(1, 4'd8, 32'd4, 32'h8000_0000);
        req_valid_i = 2'b11;
        @(negedge clk);
        check("t5_rvalid_cleared", 64'(resp_valid_o), 64'd0);
        check("t5_tie_req0", 64'(req_ready_o), 64'b01);

        // Continuous tie for 4 ops: 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            int k;
            k = 0;
            while (req_ready_o == 2'b00 && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("t6_grant_seq", 64'(req_ready_o), (i % 2 == 0) ? 64'b01 : 64'b10);
            tick();
            @(negedge clk);
        end
        req_valid_i = 2'b00;
        wait_done();
        repeat (3) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
